muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the pipelined MIPS core.

---
 rtl/muldiv_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit with HI/LO result registers. It sits in
// EX next to the combinational ALU. One operation is accepted per start
// pulse while idle; busy covers the whole iteration and done pulses for one
// cycle once HI/LO hold the final result.
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   start        request, accepted only while busy=0
//   op           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//   a            rs operand (dividend / multiplicand / MTHI-MTLO data)
//   b            rt operand (divisor / multiplier)
//   flush        synchronous abort of the in-flight operation
//   busy         operation in flight
//   done         one-cycle pulse, HI/LO were updated by the previous edge
//   div_by_zero  qualifies done: DIV/DIVU saw b==0; held until next done
//   hi, lo       HI and LO result registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Counter must reach WIDTH-1 (divide steps) and MUL_LAT-1 (<= 7).
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DPREP,
        DITER,
        DFIX
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb;     // operands latched at accept
    logic             sgn;          // signed flavour (MULT / DIV)
    logic [WIDTH-1:0] rem;          // partial remainder
    logic [WIDTH-1:0] quot;         // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;          // divisor magnitude
    logic             neg_q, neg_r; // sign fix-ups applied in DFIX

    logic accept, start_mul, start_div;

    assign accept    = (state == IDLE) && start && !flush;
    assign start_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign start_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign busy      = (state != IDLE);

    // -----------------------------------------------------------------------
    // Multiplier: both operands extended to 2*WIDTH bits so the low 2*WIDTH
    // bits of the product are exact for signed and unsigned operands alike.
    // The result is only sampled after MUL_LAT cycles.
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;

    always_comb begin
        mul_a_ext = {{WIDTH{sgn & opa[WIDTH-1]}}, opa};
        mul_b_ext = {{WIDTH{sgn & opb[WIDTH-1]}}, opb};
        product   = mul_a_ext * mul_b_ext;
    end

    // -----------------------------------------------------------------------
    // Restoring divider step. The shifted remainder needs one extra bit since
    // the divisor magnitude can use all WIDTH bits.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   shifted;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;

    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        q_bit   = (shifted >= {1'b0, dvs});
        // Result is below dvs whenever subtracted, so WIDTH bits suffice.
        rem_nxt = q_bit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    end

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        neg_a = sgn & opa[WIDTH-1];
        neg_b = sgn & opb[WIDTH-1];
        abs_a = neg_a ? -opa : opa;
        abs_b = neg_b ? -opb : opb;
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && start_mul) state_nxt = MUL;
                if (accept && start_div) state_nxt = DPREP;
            end
            MUL:   if (cnt == '0) state_nxt = IDLE;
            DPREP: state_nxt = (opb == '0) ? IDLE : DITER;
            DITER: if (cnt == '0) state_nxt = DFIX;
            DFIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // -----------------------------------------------------------------------
    // Datapath and result registers
    // -----------------------------------------------------------------------
    // NOTE: the operand and iteration registers are reset too, so that no X
    // can ever reach hi/lo through the multiplier or divider paths.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            opa         <= '0;
            opb         <= '0;
            sgn         <= 1'b0;
            rem         <= '0;
            quot        <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa <= a;
                        opb <= b;
                        sgn <= (op == OP_MULT) || (op == OP_DIV);
                        if (start_mul) cnt <= CW'(MUL_LAT - 1);
                        if (op == OP_MTHI) hi <= a;
                        if (op == OP_MTLO) lo <= a;
                    end
                end
                MUL: begin
                    if (!flush) begin
                        if (cnt == '0) begin
                            {hi, lo}    <= product;
                            done        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DPREP: begin
                    if (!flush) begin
                        if (opb == '0) begin
                            hi          <= opa;
                            lo          <= '1;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            quot  <= abs_a;
                            dvs   <= abs_b;
                            rem   <= '0;
                            neg_q <= neg_a ^ neg_b;
                            neg_r <= neg_a;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end
                end
                DITER: begin
                    if (!flush) begin
                        rem  <= rem_nxt;
                        quot <= {quot[WIDTH-2:0], q_bit};
                        cnt  <= cnt - 1'b1;
                    end
                end
                DFIX: begin
                    if (!flush) begin
                        // MIN / -1 wraps back to MIN here, which is the
                        // required overflow result.
                        lo          <= neg_q ? -quot : quot;
                        hi          <= neg_r ? -rem  : rem;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit at WIDTH=32, MUL_LAT=4. A table of
// arithmetic vectors with hand-computed results and latencies, followed by
// hand-written sequences for MTHI/MTLO, reserved ops, flush, start while
// busy, back-to-back issue and asynchronous reset mid-divide.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = WIDTH + 2;
    localparam int BOUND   = 200;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             flush;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request on the falling edge; it is sampled at the next rising
    // edge (E0). Operands are scrambled right after E0.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'hCAFEF00D;
    endtask

    // Called just after the accepting edge. lat = number of edges after E0
    // until the edge that raised done; bcnt = cycles with busy=1 before done.
    // Returns on the falling edge where done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < BOUND) begin
            @(negedge clk);
            if (done) break;
            if (busy) bcnt++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt);
        issue(o, x, y);
        wait_done(lat, bcnt);
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [31:0] hold_hi, hold_lo;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vecs[3]  = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, DIV_LAT};
        vecs[4]  = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0, MUL_LAT};
        vecs[7]  = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, DIV_LAT};
        vecs[10] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, MUL_LAT};
        vecs[12] = '{OP_DIVU,  32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, DIV_LAT};
        vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, DIV_LAT};

        rstn  = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz",  64'(div_by_zero), 64'd0);
        check("reset hi",   64'(hi), 64'd0);
        check("reset lo",   64'(lo), 64'd0);
        rstn = 1'b1;

        // ---- table-driven arithmetic vectors ----
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d busy cycles", i), 64'(bcnt), 64'(vecs[i].lat));
            check($sformatf("v%0d busy at done", i), 64'(busy), 64'd0);
            check($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("v%0d dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
            @(negedge clk);
            check($sformatf("v%0d done one cycle", i), 64'(done), 64'd0);
        end

        // ---- MTHI / MTLO ----
        issue(OP_MTHI, 32'h00000011, 32'h0);
        @(negedge clk);
        check("mthi hi", 64'(hi), 64'h11);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        issue(OP_MTLO, 32'h00000022, 32'h0);
        @(negedge clk);
        check("mtlo lo", 64'(lo), 64'h22);
        check("mtlo hi kept", 64'(hi), 64'h11);

        // ---- reserved op leaves everything alone ----
        issue(3'd6, 32'h55555555, 32'h66666666);
        @(negedge clk);
        check("rsvd busy", 64'(busy), 64'd0);
        check("rsvd done", 64'(done), 64'd0);
        check("rsvd hi", 64'(hi), 64'h11);
        check("rsvd lo", 64'(lo), 64'h22);

        // ---- flush mid-divide ----
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy after", 64'(busy), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush no done", 64'(ndone), 64'd0);
        check("flush hi kept", 64'(hi), 64'h11);
        check("flush lo kept", 64'(lo), 64'h22);
        issue(OP_MTLO, 32'h00001234, 32'h0);
        @(negedge clk);
        check("mtlo after flush", 64'(lo), 64'h1234);

        // ---- flush and start together: start dropped ----
        @(negedge clk);
        op    = OP_MTHI;
        a     = 32'h00000099;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush+start hi kept", 64'(hi), 64'h11);
        check("flush+start busy", 64'(busy), 64'd0);

        // ---- start while busy is ignored ----
        issue(OP_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        op    = OP_MTHI;
        a     = 32'h0000DEAD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("busy-start latency", 64'(lat), 64'(MUL_LAT - 1));
        check("busy-start hi", 64'(hi), 64'h0);
        check("busy-start lo", 64'(lo), 64'd15);

        // ---- back-to-back: new op accepted in the done cycle ----
        op    = OP_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b latency", 64'(lat), 64'(MUL_LAT));
        check("b2b lo", 64'(lo), 64'd42);
        check("b2b hi", 64'(hi), 64'd0);

        // ---- async reset mid-divide ----
        run_op(OP_DIV, 32'd9, 32'd0, lat, bcnt);
        check("pre-reset dbz", 64'(div_by_zero), 64'd1);
        hold_hi = hi;
        hold_lo = lo;
        check("pre-reset hi", 64'(hold_hi), 64'd9);
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid-div busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst dbz",  64'(div_by_zero), 64'd0);
        check("async rst hi",   64'(hi), 64'd0);
        check("async rst lo",   64'(lo), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("post-reset no done", 64'(ndone), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
